// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [5:0] FUNCT_JR = 6'd8;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_LW_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_JR,
    S_FAULT
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags when the wait limit is reached.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  input  logic memReady,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear)
      wait_cnt_d = '0;
    else if (waiting && !memReady)
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

  // A ready in the final allowed cycle completes normally, so memReady gates expiry.
  assign expired = (MEM_TIMEOUT != 0) && waiting && !memReady && (wait_cnt_q == LIMIT);

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing.
module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             branchNe,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             regDst,
  output logic             memToReg,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       pcSource,
  output logic             instrDone,
  output logic [CNT_W-1:0] instrCount,
  output logic             fault,
  output logic [1:0]       faultCode
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d, funct_q, funct_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             waiting, expired, timer_clear;

  assign waiting     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timer_clear = (state_d != state_q);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .waiting  (waiting),
    .memReady (memReady),
    .expired  (expired)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    funct_d      = funct_q;
    fault_code_d = fault_code_q;
    pcWrite = 1'b0; pcWriteCond = 1'b0; branchNe = 1'b0; iorD = 1'b0;
    memRead = 1'b0; memWrite = 1'b0; irWrite = 1'b0; regDst = 1'b0;
    memToReg = 1'b0; regWrite = 1'b0; aluSrcA = 1'b0; instrDone = 1'b0;
    aluSrcB = SRCB_RT; aluOp = ALU_ADD; pcSource = PCS_ALU;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d      = S_FAULT;
          fault_code_d = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMM_SH;
        op_d    = opcode;
        funct_d = funct;
        case (opcode)
          OP_R:            state_d = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_ADDI, OP_ORI: state_d = S_EXEC_I;
          OP_J:            state_d = S_JUMP;
          default: begin
            state_d      = S_FAULT;
            fault_code_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        aluSrcA = 1'b1;
        aluOp   = ALU_FUNCT;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        regDst    = 1'b1;
        // jr never reaches here; the guard keeps it from ever writing a register.
        regWrite  = (funct_q != FUNCT_JR);
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        aluOp   = (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memReady) begin
          state_d = S_LW_WB;
        end else if (expired) begin
          state_d      = S_FAULT;
          fault_code_d = FAULT_TIMEOUT;
        end
      end
      S_LW_WB: begin
        memToReg  = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_WR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (memReady) begin
          instrDone = 1'b1;
          state_d   = S_FETCH;
        end else if (expired) begin
          state_d      = S_FAULT;
          fault_code_d = FAULT_TIMEOUT;
        end
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PCS_ALUOUT;
        branchNe    = (op_q == OP_BNE);
        instrDone   = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pcWrite   = 1'b1;
        pcSource  = PCS_JUMP;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_JR: begin
        pcWrite   = 1'b1;
        pcSource  = PCS_RS;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RST;
    endcase
    instr_count_d = instr_count_q + CNT_W'(instrDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RST;
      op_q          <= '0;
      funct_q       <= '0;
      fault_code_q  <= FAULT_NONE;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      funct_q       <= funct_d;
      fault_code_q  <= fault_code_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign fault      = (state_q == S_FAULT);
  assign faultCode  = fault_code_q;
  assign instrCount = instr_count_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control with hand-derived control-word expectations.
module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        memReady;
  logic        pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite;
  logic        regDst, memToReg, regWrite, aluSrcA, instrDone, fault;
  logic [1:0]  aluSrcB, aluOp, pcSource, faultCode;
  logic [31:0] instrCount;
  logic [17:0] bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_cycle_control #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .branchNe(branchNe), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst),
    .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .pcSource(pcSource), .instrDone(instrDone), .instrCount(instrCount),
    .fault(fault), .faultCode(faultCode)
  );

  assign bus = {pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite,
                regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, instrDone};

  localparam logic [17:0] PCW  = 18'd1 << 17;
  localparam logic [17:0] PWC  = 18'd1 << 16;
  localparam logic [17:0] BNE  = 18'd1 << 15;
  localparam logic [17:0] IORD = 18'd1 << 14;
  localparam logic [17:0] MR   = 18'd1 << 13;
  localparam logic [17:0] MW   = 18'd1 << 12;
  localparam logic [17:0] IRW  = 18'd1 << 11;
  localparam logic [17:0] RDST = 18'd1 << 10;
  localparam logic [17:0] M2R  = 18'd1 << 9;
  localparam logic [17:0] RW   = 18'd1 << 8;
  localparam logic [17:0] ASA  = 18'd1 << 7;
  localparam logic [17:0] DONE = 18'd1;

  function automatic logic [17:0] sb(input logic [1:0] v); return {11'd0, v, 5'd0}; endfunction
  function automatic logic [17:0] ao(input logic [1:0] v); return {13'd0, v, 3'd0}; endfunction
  function automatic logic [17:0] ps(input logic [1:0] v); return {15'd0, v, 1'b0}; endfunction

  logic [17:0] e_fw, e_fr, e_dec, e_exr, e_rwb, e_addi, e_ori, e_iwb, e_ma, e_mrd;
  logic [17:0] e_lwwb, e_mww, e_mwr, e_beq, e_bne, e_jmp, e_jr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive memReady for one cycle, check the control word mid-cycle, advance to next negedge.
  task automatic cyc(input string tag, input logic mr, input logic [17:0] exp);
    memReady = mr;
    #1;
    chk(tag, 32'(bus), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    e_fw   = MR | sb(2'b01);
    e_fr   = e_fw | IRW | PCW;
    e_dec  = sb(2'b11);
    e_exr  = ASA | ao(2'b10);
    e_rwb  = RDST | RW | DONE;
    e_addi = ASA | sb(2'b10) | ao(2'b00);
    e_ori  = ASA | sb(2'b10) | ao(2'b11);
    e_iwb  = RW | DONE;
    e_ma   = ASA | sb(2'b10);
    e_mrd  = MR | IORD;
    e_lwwb = M2R | RW | DONE;
    e_mww  = MW | IORD;
    e_mwr  = MW | IORD | DONE;
    e_beq  = ASA | ao(2'b01) | PWC | ps(2'b01) | DONE;
    e_bne  = e_beq | BNE;
    e_jmp  = PCW | ps(2'b10) | DONE;
    e_jr   = PCW | ps(2'b11) | DONE;

    rst = 1'b1; memReady = 1'b0; opcode = 6'd0; funct = 6'd0;
    #3;
    chk("reset_bus", 32'(bus), 32'd0);
    chk("reset_count", instrCount, 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_code", 32'(faultCode), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("rst_state", 1'b0, 18'd0);

    // add
    opcode = 6'd0; funct = 6'd32;
    cyc("add_fetch", 1'b1, e_fr);
    cyc("add_decode", 1'b0, e_dec);
    cyc("add_exec", 1'b0, e_exr);
    cyc("add_wb", 1'b0, e_rwb);
    chk("add_count", instrCount, 32'd1);

    // lw with three wait cycles
    opcode = 6'd35; funct = 6'd0;
    cyc("lw_fetch", 1'b1, e_fr);
    cyc("lw_decode", 1'b0, e_dec);
    cyc("lw_addr", 1'b0, e_ma);
    for (int i = 0; i < 3; i++) cyc("lw_wait", 1'b0, e_mrd);
    cyc("lw_rd_ready", 1'b1, e_mrd);
    cyc("lw_wb", 1'b0, e_lwwb);
    chk("lw_count", instrCount, 32'd2);

    // bne then beq
    opcode = 6'd5;
    cyc("bne_fetch", 1'b1, e_fr);
    cyc("bne_decode", 1'b0, e_dec);
    cyc("bne_branch", 1'b0, e_bne);
    opcode = 6'd4;
    cyc("beq_fetch", 1'b1, e_fr);
    cyc("beq_decode", 1'b0, e_dec);
    cyc("beq_branch", 1'b0, e_beq);
    chk("branch_count", instrCount, 32'd4);

    // jr then j
    opcode = 6'd0; funct = 6'd8;
    cyc("jr_fetch", 1'b1, e_fr);
    cyc("jr_decode", 1'b0, e_dec);
    cyc("jr_exec", 1'b0, e_jr);
    opcode = 6'd2; funct = 6'd0;
    cyc("j_fetch", 1'b1, e_fr);
    cyc("j_decode", 1'b0, e_dec);
    cyc("j_exec", 1'b0, e_jmp);
    chk("jump_count", instrCount, 32'd6);

    // addi, with the opcode bus changed after DECODE to prove latching
    opcode = 6'd8;
    cyc("addi_fetch", 1'b1, e_fr);
    cyc("addi_decode", 1'b0, e_dec);
    opcode = 6'd63;
    cyc("addi_exec", 1'b0, e_addi);
    cyc("addi_wb", 1'b0, e_iwb);
    opcode = 6'd13;
    cyc("ori_fetch", 1'b1, e_fr);
    cyc("ori_decode", 1'b0, e_dec);
    cyc("ori_exec", 1'b0, e_ori);
    cyc("ori_wb", 1'b0, e_iwb);
    chk("imm_count", instrCount, 32'd8);

    // sw with zero wait
    opcode = 6'd43;
    cyc("sw_fetch", 1'b1, e_fr);
    cyc("sw_decode", 1'b0, e_dec);
    cyc("sw_addr", 1'b0, e_ma);
    cyc("sw_write", 1'b1, e_mwr);
    chk("sw_count", instrCount, 32'd9);

    // illegal opcode
    opcode = 6'd63;
    cyc("ill_fetch", 1'b1, e_fr);
    cyc("ill_decode", 1'b0, e_dec);
    for (int i = 0; i < 20; i++) begin
      memReady = i[0];
      #1;
      chk("ill_bus", 32'(bus), 32'd0);
      chk("ill_fault", 32'(fault), 32'd1);
      chk("ill_code", 32'(faultCode), 32'd1);
      @(negedge clk);
    end
    chk("ill_count", instrCount, 32'd9);

    rst = 1'b1;
    #1;
    chk("rst2_bus", 32'(bus), 32'd0);
    chk("rst2_fault", 32'(fault), 32'd0);
    chk("rst2_code", 32'(faultCode), 32'd0);
    chk("rst2_count", instrCount, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("rst2_state", 1'b0, 18'd0);

    // fetch watchdog: 16 cycles without ready
    for (int i = 0; i < 16; i++) cyc("wd_wait", 1'b0, e_fw);
    #1;
    chk("wd_fault", 32'(fault), 32'd1);
    chk("wd_code", 32'(faultCode), 32'd2);
    chk("wd_bus", 32'(bus), 32'd0);
    @(negedge clk);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc("rst3_state", 1'b0, 18'd0);

    // ready on the 16th cycle wins
    opcode = 6'd2;
    for (int i = 0; i < 15; i++) cyc("wd_edge_wait", 1'b0, e_fw);
    cyc("wd_edge_ready", 1'b1, e_fr);
    cyc("wd_edge_decode", 1'b0, e_dec);
    cyc("wd_edge_jump", 1'b0, e_jmp);
    chk("wd_edge_fault", 32'(fault), 32'd0);
    chk("wd_edge_count", instrCount, 32'd1);

    // async reset during a MEM_WR wait
    opcode = 6'd43;
    cyc("sw2_fetch", 1'b1, e_fr);
    cyc("sw2_decode", 1'b0, e_dec);
    cyc("sw2_addr", 1'b0, e_ma);
    memReady = 1'b0;
    #1;
    chk("sw2_wait", 32'(bus), 32'(e_mww));
    #2;
    rst = 1'b1;
    #1;
    chk("async_memwrite", 32'(memWrite), 32'd0);
    chk("async_bus", 32'(bus), 32'd0);
    chk("async_count", instrCount, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("async_rst_state", 1'b0, 18'd0);
    cyc("async_fetch", 1'b1, e_fr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
Multi-cycle sequencer for the MIPS datapath, replacing single-cycle decode with a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared ALU, the unified instruction/data memory port, IR, PC and register-file enables. It supports a variable-latency memory handshake with a watchdog, and counts retired instructions. Supported: R-type (incl. jr), beq, bne, lw, sw, addi, ori, j.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting for memReady in any memory state; 0 disables the watchdog
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
memReady  in  1  memory completes current read/write this cycle
pcWrite  out  1  unconditional PC load
pcWriteCond  out  1  PC load if branch condition holds
branchNe  out  1  1 = condition is ALU zero==0 (bne); 0 = zero==1 (beq)
iorD  out  1  memory address: 0 = PC, 1 = ALUOut
memRead  out  1  memory read request
memWrite  out  1  memory write request
irWrite  out  1  IR load
regDst  out  1  1 = rd, 0 = rt
memToReg  out  1  1 = MDR to regfile
regWrite  out  1  regfile write enable
aluSrcA  out  1  0 = PC, 1 = rs
aluSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
aluOp  out  2  00 add, 01 sub, 10 funct, 11 or
pcSource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 rs (jr)
instrDone  out  1  one-cycle pulse on the last cycle of each instruction
instrCount  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
fault  out  1  sticky error
faultCode  out  2  01 illegal opcode, 10 memory timeout, 00 none

Behaviour:
- rst asserted: state = RST, instrCount = 0, fault = 0, faultCode = 00, latched opcode/funct = 0, all outputs 0. Effect is immediate, including mid-instruction.
- Default for every output is 0. Each state lists only its non-zero outputs.
- RST: -> FETCH.
- FETCH: memRead=1, aluSrcB=01. Waits for memReady. In the memReady cycle, also irWrite=1 and pcWrite=1 (Mealy), then -> DECODE.
- DECODE: aluSrcB=11 (branch target precomputed into ALUOut). Latches opcode/funct internally; later states use only the latched copies. Dispatch:
  - op 0 with funct 8 -> JR
  - op 0 -> EXEC_R
  - op 4 or 5 -> BRANCH
  - op 35 or 43 -> MEM_ADDR
  - op 8 or 13 -> EXEC_I
  - op 2 -> JUMP
  - any other opcode -> FAULT with faultCode = 01
- EXEC_R: aluSrcA=1, aluOp=10 -> R_WB.
- R_WB: regDst=1, regWrite=1, instrDone -> FETCH.
- EXEC_I: aluSrcA=1, aluSrcB=10, aluOp=00 (addi) or 11 (ori) -> I_WB.
- I_WB: regWrite=1, instrDone -> FETCH.
- MEM_ADDR: aluSrcA=1, aluSrcB=10 -> MEM_RD (op 35) or MEM_WR (op 43).
- MEM_RD: memRead=1, iorD=1. Waits for memReady -> LW_WB.
- LW_WB: memToReg=1, regWrite=1, instrDone -> FETCH.
- MEM_WR: memWrite=1, iorD=1. Waits for memReady; in that cycle instrDone=1 -> FETCH.
- BRANCH: aluSrcA=1, aluOp=01, pcWriteCond=1, pcSource=01, branchNe=(op==5), instrDone -> FETCH.
- JUMP: pcWrite=1, pcSource=10, instrDone -> FETCH.
- JR: pcWrite=1, pcSource=11, instrDone -> FETCH. regWrite is never asserted for jr.
- FAULT: all datapath outputs 0, fault=1. Held until rst.
- Latency with zero-wait memory, counting the FETCH cycle:
  - R-type, addi/ori: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne, j, jr: 3 cycles
- Every memory wait cycle adds 1 cycle.
- memReady is ignored outside FETCH, MEM_RD and MEM_WR. Request outputs stay asserted and stable for every cycle of a wait.
- Watchdog: waitCnt clears on entry to each memory state and increments on each cycle with memReady=0. If memReady=0 and waitCnt == MEM_TIMEOUT-1, go to FAULT with faultCode = 10. memReady=1 in that same cycle wins and completes normally.
- instrCount increments in every instrDone cycle and wraps from all-ones to 0 without flagging.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants: R 0, J 2, BEQ 4, BNE 5, ADDI 8, ORI 13, LW 35, SW 43
  - FUNCT_JR = 8
  - aluOp, aluSrcB and pcSource encodings
  - faultCode values
  - state enumeration
- Sub-module mem_wait_timer: waitCnt plus timeout compare, with inputs clear, waiting, memReady and output expired. The FSM, output decode and counter stay in multi_cycle_control.

Test Plan:
- add (op 0, funct 32), memReady=1 -> FETCH/DECODE/EXEC_R/R_WB over 4 cycles; regDst=1, regWrite=1 only in cycle 4; instrDone pulses once; instrCount 0->1.
- lw (op 35), memReady low 3 cycles in MEM_RD -> memRead=1 and iorD=1 held 4 cycles; then LW_WB with memToReg=1, regWrite=1; total 8 cycles.
- bne (op 5) then beq (op 4) -> BRANCH with pcWriteCond=1, pcSource=01, aluOp=01; branchNe=1 then 0; regWrite never 1.
- jr (op 0, funct 8) -> JR with pcWrite=1, pcSource=11, regWrite=0 throughout; j (op 2) -> pcSource=10.
- op 63 -> FAULT, fault=1, faultCode=01, held 20 cycles; rst -> all outputs 0, then FETCH. Separately, memReady held 0 in FETCH with MEM_TIMEOUT=16 -> faultCode=10 after exactly 16 cycles; memReady=1 on cycle 16 -> no fault.
- rst asserted asynchronously mid-MEM_WR -> memWrite drops immediately, instrCount=0; the first post-reset cycle is RST, then FETCH.
